// File: rtl/pc_sequencer_if.sv
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Bundle of the instruction-fetch handshake, the execute-stage
//                next-PC controls and the PC status outputs of pc_sequencer.
//                The "master" modport is the sequencer itself; the "slave"
//                modport is the surrounding core (instruction memory plus
//                execute path).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_W = 32
) ();

    // Instruction-memory fetch handshake
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;

    // Status towards the execute path
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic              addr_err;

    // Next-PC controls, meaningful only on the commit edge
    logic              commit;
    logic              stall;
    logic              pc_src;
    logic [ADDR_W-1:0] branch_offset;
    logic              jump;
    logic [25:0]       jump_target;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;

    // Sequencer side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        output instr_valid,
        output pc,
        output pc_plus4,
        output addr_err,
        input  commit,
        input  stall,
        input  pc_src,
        input  branch_offset,
        input  jump,
        input  jump_target,
        input  jr,
        input  jr_target
    );

    // Core / memory side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        input  instr_valid,
        input  pc,
        input  pc_plus4,
        input  addr_err,
        output commit,
        output stall,
        output pc_src,
        output branch_offset,
        output jump,
        output jump_target,
        output jr,
        output jr_target
    );

endinterface : pc_sequencer_if

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter owner for the MIPS core. Fetches each
//                instruction over a req/ack handshake, holds it in EXEC
//                until execute commits, then loads the next PC chosen by
//                jr > jump > branch > sequential priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    pc_sequencer_if.master    bus
);

    // Word alignment is architectural, so the low bits of the reset vector
    // are forced to zero rather than trusted.
    localparam logic [ADDR_W-1:0] c_reset_pc = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] c_four     = ADDR_W'(4);

    typedef enum logic [1:0] {
        ST_RESET_HOLD = 2'd0,
        ST_FETCH      = 2'd1,
        ST_EXEC       = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] r_pc;
    logic              r_addr_err;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_branch_pc;
    logic [ADDR_W-1:0] w_jump_pc;
    logic [ADDR_W-1:0] w_jr_pc;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_commit_fire;
    logic              w_jr_misaligned;
    logic              w_imem_req;
    logic              w_instr_valid;

    // ------------------------------------------------------------------
    // Next-PC candidates. All arithmetic is modulo 2^ADDR_W, so pc_plus4
    // wraps to zero at the top of the address space and branches may wrap
    // in either direction.
    // ------------------------------------------------------------------
    assign w_pc_plus4      = r_pc + c_four;
    assign w_branch_pc     = w_pc_plus4 + (bus.branch_offset << 2);
    assign w_jump_pc       = {w_pc_plus4[ADDR_W-1:ADDR_W-4], bus.jump_target, 2'b00};
    assign w_jr_pc         = {bus.jr_target[ADDR_W-1:2], 2'b00};
    assign w_jr_misaligned = (bus.jr_target[1:0] != 2'b00);

    // A commit only counts in EXEC and only when no hazard is holding it.
    assign w_commit_fire   = (r_state == ST_EXEC) && bus.commit && !bus.stall;

    // Select the next PC with jr > jump > branch > sequential priority.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (bus.jr) begin
            w_next_pc = w_jr_pc;
        end else if (bus.jump) begin
            w_next_pc = w_jump_pc;
        end else if (bus.pc_src) begin
            w_next_pc = w_branch_pc;
        end
    end

    // State register; reset drops straight into RESET_HOLD without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RESET_HOLD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from the current state only
    // so that asserting rst removes imem_req immediately.
    always_comb begin
        w_state_nxt   = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        case (r_state)
            ST_RESET_HOLD: begin
                // One idle cycle after reset release before the first fetch.
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                // Request stays up until acknowledged; stall is ignored here.
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_instr_valid = 1'b1;
                if (w_commit_fire) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_RESET_HOLD;
            end
        endcase
    end

    // PC register: changes only on a committed instruction, which keeps the
    // fetch address stable for the whole FETCH phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= c_reset_pc;
        end else if (w_commit_fire) begin
            r_pc <= w_next_pc;
        end
    end

    // Sticky misaligned-jr flag; only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else if (w_commit_fire && bus.jr && w_jr_misaligned) begin
            r_addr_err <= 1'b1;
        end
    end

    assign bus.imem_req    = w_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = w_instr_valid;
    assign bus.pc          = r_pc;
    assign bus.pc_plus4    = w_pc_plus4;
    assign bus.addr_err    = r_addr_err;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed self-checking bench for pc_sequencer: reset,
//                sequential fetch, branch/jump/jr priority, sticky addr_err,
//                PC wrap, slow memory, stall, and reset during a fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks = 0;
    int errors = 0;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        bus.commit        = 1'b0;
        bus.stall         = 1'b0;
        bus.pc_src        = 1'b0;
        bus.branch_offset = 32'h0;
        bus.jump          = 1'b0;
        bus.jump_target   = 26'h0;
        bus.jr            = 1'b0;
        bus.jr_target     = 32'h0;
    endtask

    // From EXEC: commit with the given controls (memory acks at once),
    // check the new fetch address, then move on into EXEC.
    task automatic commit_op(input string tag,
                             input logic i_jr, input logic [31:0] i_jrt,
                             input logic i_jmp, input logic [25:0] i_jt,
                             input logic i_src, input logic [31:0] i_off,
                             input logic [31:0] exp_addr);
        chk({tag, "_in_exec"}, {31'd0, bus.instr_valid}, 32'd1);
        bus.jr            = i_jr;
        bus.jr_target     = i_jrt;
        bus.jump          = i_jmp;
        bus.jump_target   = i_jt;
        bus.pc_src        = i_src;
        bus.branch_offset = i_off;
        bus.commit        = 1'b1;
        step();
        clear_ctrl();
        chk({tag, "_addr"}, bus.imem_addr, exp_addr);
        chk({tag, "_req"}, {31'd0, bus.imem_req}, 32'd1);
        step();
    endtask

    initial begin
        clear_ctrl();
        bus.imem_ack = 1'b0;

        // Asynchronous reset: outputs settle before any clock edge.
        #1 rst = 1'b1;
        #1;
        chk("rst_req",      {31'd0, bus.imem_req},    32'd0);
        chk("rst_valid",    {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_pc",       bus.pc,                   32'h0);
        chk("rst_addr_err", {31'd0, bus.addr_err},    32'd0);

        // Release with memory acking every cycle and commit held high.
        step();
        step();
        rst          = 1'b0;
        bus.imem_ack = 1'b1;
        bus.commit   = 1'b1;
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        step();
        chk("f0_req",   {31'd0, bus.imem_req},    32'd1);
        chk("f0_addr",  bus.imem_addr,            32'h0);
        chk("f0_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        chk("e0_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("e0_req",   {31'd0, bus.imem_req},    32'd0);
        chk("e0_pc4",   bus.pc_plus4,             32'h4);
        step();
        chk("f1_addr",  bus.imem_addr,            32'h4);
        chk("f1_valid", {31'd0, bus.instr_valid}, 32'd0);
        step();
        chk("e1_valid", {31'd0, bus.instr_valid}, 32'd1);
        step();
        chk("f2_addr",  bus.imem_addr,            32'h8);
        bus.commit = 1'b0;
        step();
        // EXEC at pc=8

        // Branch backwards from 0x100: 0x104 + (-2 << 2) = 0xFC.
        commit_op("jr_100",  1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0100);
        chk("pc4_100", bus.pc_plus4, 32'h0000_0104);
        commit_op("br_back", 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE, 32'h0000_00FC);
        commit_op("jr_100b", 1'b1, 32'h0000_0100, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0100);
        commit_op("br_nt",   1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'hFFFF_FFFE, 32'h0000_0104);

        // Jump beats branch; upper nibble comes from pc+4.
        commit_op("jr_3k",   1'b1, 32'h3000_0010, 1'b0, 26'h0, 1'b0, 32'h0, 32'h3000_0010);
        commit_op("jmp",     1'b0, 32'h0, 1'b1, 26'h000_0040, 1'b1, 32'h0000_0010, 32'h3000_0100);
        chk("no_err_yet", {31'd0, bus.addr_err}, 32'd0);

        // jr beats jump; misaligned target is truncated and flagged.
        commit_op("jr_mis",  1'b1, 32'h0000_2002, 1'b1, 26'h3FF_FFFF, 1'b0, 32'h0, 32'h0000_2000);
        chk("err_set", {31'd0, bus.addr_err}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            commit_op("seq", 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_2000 + 32'(i * 4));
        end
        chk("err_sticky", {31'd0, bus.addr_err}, 32'd1);

        // Wrap at the top of the address space.
        commit_op("jr_top",  1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0, 32'hFFFF_FFFC);
        chk("pc4_wrap", bus.pc_plus4, 32'h0);
        commit_op("wrap",    1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0);
        commit_op("jr_200",  1'b1, 32'h0000_0200, 1'b0, 26'h0, 1'b0, 32'h0, 32'h0000_0200);

        // Slow memory: three cycles without ack, so four FETCH cycles.
        bus.imem_ack = 1'b0;
        bus.commit   = 1'b1;
        step();
        clear_ctrl();
        chk("slow_req0",  {31'd0, bus.imem_req}, 32'd1);
        chk("slow_addr0", bus.imem_addr,         32'h0000_0204);
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;  // no effect while fetching
            step();
            chk("slow_req",   {31'd0, bus.imem_req},    32'd1);
            chk("slow_addr",  bus.imem_addr,            32'h0000_0204);
            chk("slow_valid", {31'd0, bus.instr_valid}, 32'd0);
            bus.imem_ack = (i == 2);
        end
        step();
        chk("slow_exec", {31'd0, bus.instr_valid}, 32'd1);

        // Stall holds EXEC for two edges despite commit.
        bus.commit = 1'b1;
        bus.stall  = 1'b1;
        bus.pc_src = 1'b1;
        bus.branch_offset = 32'h0000_0010;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_pc",    bus.pc,                   32'h0000_0204);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
        end
        bus.stall = 1'b0;
        step();
        clear_ctrl();
        chk("unstall_addr", bus.imem_addr, 32'h0000_0248);
        chk("unstall_req",  {31'd0, bus.imem_req}, 32'd1);

        // Reset mid-FETCH while the ack is arriving.
        bus.imem_ack = 1'b0;
        #3 bus.imem_ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_pc",  bus.pc,                32'h0);
        chk("mid_rst_err", {31'd0, bus.addr_err}, 32'd0);
        step();
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_rst_req2",  {31'd0, bus.imem_req},    32'd0);
        rst = 1'b0;
        step();
        chk("restart_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("restart_addr", bus.imem_addr,         32'h0);
        step();
        chk("restart_exec", {31'd0, bus.instr_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pc_sequencer

`default_nettype wire
